// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported unified memory.
// Data wins a tie unless it was granted last; a RESP blanking cycle after each
// access keeps a still-held request from being re-accepted.
// Optional watchdog on WAIT states: define MEMARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  typedef enum logic [2:0] {StIdle, StDWait, StIWait, StDResp, StIResp} state_e;

  // last_grant encoding: 1 = data was granted last, 0 = instruction
  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_d;

`ifdef MEMARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            expired;
  assign expired = (cnt_q == CntW'(TIMEOUT - 1));
  assign err     = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err            = 1'b0;
`endif

  // Arbitration, memory handshake sequencing and read-data capture
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    last_grant_d = last_grant_q;
    grant_d      = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (d_req && (!i_req || !last_grant_q)) begin
          state_d      = StDWait;
          mem_req_d    = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          last_grant_d = 1'b1;
          grant_d      = 1'b1;
        end else if (i_req) begin
          state_d      = StIWait;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = i_addr;
          mem_wdata_d  = '0;
          last_grant_d = 1'b0;
          grant_d      = 1'b1;
        end
      end
      StDWait: begin
        if (mem_ack) begin
          if (!mem_we_q) d_rdata_d = mem_rdata;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StDResp;
        end
`ifdef MEMARB_TIMEOUT_EN
        else if (expired) begin
          if (!mem_we_q) d_rdata_d = DATA_W'(32'hDEAD_BEEF);
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StDResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StIWait: begin
        if (mem_ack) begin
          i_rdata_d = mem_rdata;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StIResp;
        end
`ifdef MEMARB_TIMEOUT_EN
        else if (expired) begin
          i_rdata_d = DATA_W'(32'hDEAD_BEEF);
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StIResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StDResp: state_d = StIdle;
      StIResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef MEMARB_TIMEOUT_EN
    if (grant_d) cnt_d = '0;
`endif
  end

  // State and registered memory-side outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      last_grant_q <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      last_grant_q <= last_grant_d;
`ifdef MEMARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  // Ready pulses come straight from the RESP states; stalls drop with them
  always_comb begin
    i_ready = (state_q == StIResp);
    d_ready = (state_q == StDResp);
    stall_f = i_req & ~i_ready;
    stall_m = d_req & ~d_ready;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        stall_f;
  logic        stall_m;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ready  (i_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .stall_f  (stall_f),
    .stall_m  (stall_m),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_readys", {i_ready, d_ready}, 0);
    chk("rst_err", err, 0);

    // Single load, ack two cycles after mem_req rises
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    #1 chk("ld_stall_m_idle", stall_m, 1);
    step();
    chk("ld_mem_req", mem_req, 1);
    chk("ld_mem_addr", mem_addr, 32'h40);
    chk("ld_mem_we", mem_we, 0);
    step();
    chk("ld_hold_req", mem_req, 1);
    chk("ld_stall_m_wait", stall_m, 1);
    chk("ld_no_ready", d_ready, 0);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    chk("ld_d_ready", d_ready, 1);
    chk("ld_d_rdata", d_rdata, 32'h1234_5678);
    chk("ld_stall_m_resp", stall_m, 0);
    chk("ld_req_drop", mem_req, 0);
    d_req = 1'b0;
    step();
    chk("ld_ready_pulse", d_ready, 0);

    // Store with zero-wait ack
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFE_F00D;
    step();
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("st_mem_addr", mem_addr, 32'h80);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    mem_ack = 1'b0;
    chk("st_d_ready", d_ready, 1);
    chk("st_d_rdata_kept", d_rdata, 32'h1234_5678);
    chk("st_we_drop", mem_we, 0);
    d_req = 1'b0; d_we = 1'b0;
    step();

    // Simultaneous requests from reset: D, I, D, I
    reset = 1'b1;
    step();
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("alt_req", mem_req, 1);
      chk("alt_addr", mem_addr, (k % 2 == 0) ? 32'h200 : 32'h100);
      mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + k;
      step();
      mem_ack = 1'b0;
      chk("alt_readys", {i_ready, d_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("alt_rdata", (k % 2 == 0) ? d_rdata : i_rdata, 32'hA000_0000 + k);
      step();
      chk("alt_idle_req", mem_req, 0);
      chk("alt_idle_readys", {i_ready, d_ready}, 0);
      if (k == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    step();
    chk("alt_no_extra", mem_req, 0);

    // Fetch held one cycle past i_ready
    i_req = 1'b1; i_addr = 32'h300;
    step();
    chk("if_mem_req", mem_req, 1);
    chk("if_mem_addr", mem_addr, 32'h300);
    chk("if_mem_wdata", mem_wdata, 0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 1'b0;
    chk("if_i_ready", i_ready, 1);
    chk("if_i_rdata", i_rdata, 32'h0BAD_F00D);
    chk("if_stall_f_resp", stall_f, 0);
    step();
    chk("if_blank_req", mem_req, 0);
    chk("if_stall_f_idle", stall_f, 1);
    i_req = 1'b0;
    step();
    chk("if_no_refetch", mem_req, 0);
    chk("if_ready_once", i_ready, 0);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    chk("stray_ack_rdata", i_rdata, 32'h0BAD_F00D);
    chk("stray_ack_ready", {i_ready, d_ready}, 0);

    // Reset in the middle of D_WAIT
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h55;
    step();
    chk("rw_mem_req", mem_req, 1);
    reset = 1'b1;
    step();
    chk("rw_mem_req_rst", mem_req, 0);
    chk("rw_mem_we_rst", mem_we, 0);
    chk("rw_mem_addr_rst", mem_addr, 0);
    chk("rw_mem_wdata_rst", mem_wdata, 0);
    chk("rw_rdata_rst", i_rdata | d_rdata, 0);
    chk("rw_readys_rst", {i_ready, d_ready}, 0);
    reset = 1'b0; d_we = 1'b0; d_addr = 32'h48;
    step();
    chk("rw_regrant", mem_req, 1);
    chk("rw_regrant_addr", mem_addr, 32'h48);
    mem_ack = 1'b1; mem_rdata = 32'h77;
    step();
    mem_ack = 1'b0;
    chk("rw_d_ready", d_ready, 1);
    chk("rw_d_rdata", d_rdata, 32'h77);
    d_req = 1'b0;
    step();

    // Memory never acknowledges
    i_req = 1'b1; i_addr = 32'h500;
    step();
`ifdef MEMARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      step();
      chk("to_wait_req", mem_req, 1);
      chk("to_wait_ready", i_ready, 0);
    end
    step();
    chk("to_ready", i_ready, 1);
    chk("to_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("to_err", err, 1);
    chk("to_req_drop", mem_req, 0);
    i_req = 1'b0;
    step(); step();
    chk("to_err_sticky", err, 1);
`else
    for (int k = 0; k < 20; k++) begin
      step();
      chk("noack_req", mem_req, 1);
      chk("noack_ready", i_ready, 0);
    end
    chk("noack_err", err, 0);
    chk("noack_stall_f", stall_f, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the pipeline's fetch stage (instruction port) and memory stage (data port). It sequences each access through a registered request/acknowledge handshake with the memory. It returns read data and a one-cycle ready pulse to the winning requester, and drives per-stage stall signals into the hazard logic so the datapath freezes while an access is outstanding. Arbitration prefers the data port but alternates whenever both ports are waiting, so neither port starves.

## Interface
- ADDR_W, 32, address width of both ports and the memory
- DATA_W, 32, data width of both ports and the memory
- TIMEOUT, 255, watchdog limit in cycles spent in a WAIT state (used only with MEMARB_TIMEOUT_EN; minimum 1)
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch requests a read; held high until i_ready is seen
- i_addr  in  ADDR_W  fetch address (PCF)
- i_rdata  out  DATA_W  fetched instruction; updated only when an instruction access completes
- i_ready  out  1  one-cycle pulse: i_rdata is valid
- d_req  in  1  memory stage requests an access; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (ALUOutM)
- d_wdata  in  DATA_W  store data (WriteDataM)
- d_rdata  out  DATA_W  load data; updated only on load completion
- d_ready  out  1  one-cycle pulse: data access finished
- stall_f  out  1  combinational i_req & ~i_ready
- stall_m  out  1  combinational d_req & ~d_ready
- mem_req  out  1  registered request to memory; held until mem_ack
- mem_we  out  1  registered write enable
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid in the mem_ack cycle
- mem_ack  in  1  memory completes the current request this cycle
- err  out  1  sticky timeout flag (constant 0 without MEMARB_TIMEOUT_EN)

## Operation
- States: IDLE, D_WAIT, I_WAIT, D_RESP, I_RESP.
- IDLE, arbitration:
  - Only d_req: go to D_WAIT.
  - Only i_req: go to I_WAIT.
  - Both: the winner is data unless last_grant == DATA, in which case instruction wins.
  - On entering a WAIT state, latch mem_req=1, mem_we (d_we for data, 0 for instruction), mem_addr and mem_wdata (0 for instruction).
  - last_grant updates on every grant.
- WAIT states: the latched memory outputs hold stable. When mem_ack=1:
  - Data: capture mem_rdata into d_rdata if the access is a load; stores leave d_rdata unchanged.
  - Instruction: capture mem_rdata into i_rdata.
  - Drop mem_req and mem_we, and go to the matching RESP state.
- RESP states: assert the matching ready for exactly this one cycle, grant nothing, then go to IDLE. This blanking cycle is what stops a request still held high from being re-accepted.
- Requester inputs are sampled only in IDLE. Changes to a requester's inputs while it is in WAIT are ignored.
- mem_ack outside a WAIT state is ignored.
- Reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_rdata=0, d_rdata=0, i_ready=0, d_ready=0, last_grant=INSTR (so data wins the first tie), err=0. Reset during WAIT abandons the access: mem_req is low after the reset edge, and the memory tolerates this.

## Timing
- Request first seen in IDLE at cycle N: mem_req is high from N+1.
- mem_ack at cycle M (M ≥ N+1): ready is high and data is valid at M+1, and the arbiter is back in IDLE at M+2.
- Minimum round trip: 3 cycles from req to IDLE; ready at N+2 when mem_ack is zero-wait.
- A losing port waits at least until the winner's RESP cycle has passed. With both ports continuously requesting, grants alternate D, I, D, I…
- stall_f and stall_m are combinational and drop in the ready cycle, so the pipeline register advances on that edge.

## Configuration
- MEMARB_TIMEOUT_EN defined:
  - A wait counter clears on entry to a WAIT state and increments each WAIT cycle without mem_ack.
  - When it reaches TIMEOUT: set err (sticky until reset), drop mem_req, load rdata with 32'hDEADBEEF for both loads and fetches, and go to RESP.
  - If mem_ack and the timeout occur in the same cycle, mem_ack wins.
- MEMARB_TIMEOUT_EN not defined: no counter, WAIT lasts until mem_ack, err is tied to 0.

## Test plan
- Single load: d_req=1, d_we=0, d_addr=0x40, with mem_ack 2 cycles after mem_req rises and mem_rdata=0x1234_5678 → mem_addr=0x40, mem_we=0, d_ready pulses one cycle with d_rdata=0x1234_5678, and stall_m is high until that cycle.
- Store: d_we=1, d_addr=0x80, d_wdata=0xCAFE_F00D, zero-wait ack → mem_we=1 with that data; d_ready pulses at N+2; d_rdata unchanged.
- Simultaneous requests from reset, both held for 4 transactions → grant order D, I, D, I, with exactly one ready pulse per transaction and no duplicate grant while req is still high.
- Request held through RESP: i_req stays high for 1 cycle after i_ready → exactly one mem_req, no second fetch.
- Reset asserted mid-D_WAIT → mem_req=0, all outputs at their reset values next cycle, and a new d_req is granted normally.
- With MEMARB_TIMEOUT_EN and TIMEOUT=4, mem_ack never asserted → ready pulses after 4 WAIT cycles with rdata=0xDEADBEEF, err=1 and held; without the macro, mem_req stays high indefinitely and err=0.
